apb4_sram_ws: RTL and testbench

//  APB4 slave RAM, successor to the single-cycle APB RAM. Adds byte strobes, programmable wait states,

---
 rtl/apb4_sram_pkg.sv | 28 ++
 rtl/apb4_sram_array.sv | 45 ++++
 rtl/apb4_sram_ws.sv | 148 ++++++++++++++
 tb/tb_apb4_sram_ws.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb4_sram_pkg.sv
// Shared types and helpers for the APB4 wait-state SRAM slave.
package apb4_sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wait counter width; covers WAIT_STATES up to 15.
    localparam int unsigned CNT_W = 4;

    // Number of byte-offset address bits within one bus word.
    function automatic int unsigned lsb_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // Expand byte strobes to a bit mask; sized for the widest supported bus (64 bits).
    function automatic logic [63:0] strb_mask(input logic [7:0] strb);
        logic [63:0] mask;
        mask = '0;
        for (int b = 0; b < 8; b++) begin
            mask[8*b +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/apb4_sram_array.sv
// Word-addressed RAM: one synchronous read port, one byte-masked write port.
module apb4_sram_array
    import apb4_sram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_re,
    input  logic                    i_rclr,
    input  logic [IDX_W-1:0]        i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    input  logic                    i_we,
    input  logic [IDX_W-1:0]        i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [63:0]           w_mask;

    assign w_mask  = strb_mask(8'(i_wstrb));
    assign o_rdata = r_rdata;

    // Byte-masked write; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= DATA_WIDTH'((64'(r_mem[i_waddr]) & ~w_mask) |
                                          (64'(i_wdata) & w_mask));
        end
    end

    // Read register: loads a word (or zero for an erroring access) and holds it otherwise.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rclr ? '0 : r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/apb4_sram_ws.sv
// APB4 slave RAM with byte strobes, programmable wait states and error response.
module apb4_sram_ws
    import apb4_sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    i_pclk,
    input  logic                    i_presetn,
    input  logic                    i_psel,
    input  logic                    i_penable,
    input  logic                    i_pwrite,
    input  logic [ADDR_WIDTH-1:0]   i_paddr,
    input  logic [DATA_WIDTH-1:0]   i_pwdata,
    input  logic [DATA_WIDTH/8-1:0] i_pstrb,
    output logic [DATA_WIDTH-1:0]   o_prdata,
    output logic                    o_pready,
    output logic                    o_pslverr
);

    localparam int unsigned LSB   = lsb_bits(DATA_WIDTH);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    state_t           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_write, w_write_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic             r_err, w_err_next;
    logic             r_pready, w_pready_next;
    logic             r_pslverr, w_pslverr_next;

    logic [ADDR_WIDTH-1:0] w_word;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;
    logic                  w_re;
    logic                  w_rclr;
    logic [IDX_W-1:0]      w_raddr;
    logic                  w_we;

    // Address decode, only meaningful at the setup edge.
    assign w_word = i_paddr >> LSB;
    assign w_idx  = w_word[IDX_W-1:0];
    assign w_err  = ((i_paddr & LSB_MASK) != '0) || (32'(w_word) >= DEPTH_WORDS);

    assign o_pready  = r_pready;
    assign o_pslverr = r_pslverr;

    // State and output registers with synchronous reset.
    always_ff @(posedge i_pclk) begin
        if (!i_presetn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_write   <= w_write_next;
            r_idx     <= w_idx_next;
            r_err     <= w_err_next;
            r_pready  <= w_pready_next;
            r_pslverr <= w_pslverr_next;
        end
    end

    // Next-state, completion flags and array port control.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_write_next   = r_write;
        w_idx_next     = r_idx;
        w_err_next     = r_err;
        w_pready_next  = 1'b0;
        w_pslverr_next = 1'b0;
        w_re           = 1'b0;
        w_rclr         = 1'b0;
        w_raddr        = r_idx;
        w_we           = 1'b0;
        unique case (r_state)
            IDLE: begin
                // PENABLE without a preceding setup is ignored.
                if (i_psel && !i_penable) begin
                    w_write_next = i_pwrite;
                    w_idx_next   = w_idx;
                    w_err_next   = w_err;
                    w_cnt_next   = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        w_state_next   = DONE;
                        w_pready_next  = 1'b1;
                        w_pslverr_next = w_err;
                        w_re           = !i_pwrite;
                        w_rclr         = w_err;
                        w_raddr        = w_idx;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!i_psel) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (i_penable) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next   = DONE;
                        w_pready_next  = 1'b1;
                        w_pslverr_next = r_err;
                        w_re           = !r_write;
                        w_rclr         = r_err;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
                // Commit at the edge closing the PREADY cycle; an abort or reset here drops it.
                w_we = i_psel && i_penable && r_write && !r_err && i_presetn;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    apb4_sram_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .i_clk   (i_pclk),
        .i_rst_n (i_presetn),
        .i_re    (w_re),
        .i_rclr  (w_rclr),
        .i_raddr (w_raddr),
        .o_rdata (o_prdata),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (i_pwdata),
        .i_wstrb (i_pstrb)
    );

endmodule

// File: tb/tb_apb4_sram_ws.sv
// Directed bench: one instance with 2 wait states, one with none.
module tb_apb4_sram_ws;

    logic        clk;
    logic        presetn;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready, pslverr;

    logic        b_psel, b_penable, b_pwrite;
    logic [11:0] b_paddr;
    logic [31:0] b_pwdata;
    logic [3:0]  b_pstrb;
    logic [31:0] b_prdata;
    logic        b_pready, b_pslverr;

    int n_cmp = 0;
    int n_err = 0;

    apb4_sram_ws #(
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (256),
        .WAIT_STATES (2)
    ) dut (
        .i_pclk    (clk),
        .i_presetn (presetn),
        .i_psel    (psel),
        .i_penable (penable),
        .i_pwrite  (pwrite),
        .i_paddr   (paddr),
        .i_pwdata  (pwdata),
        .i_pstrb   (pstrb),
        .o_prdata  (prdata),
        .o_pready  (pready),
        .o_pslverr (pslverr)
    );

    apb4_sram_ws #(
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (32),
        .DEPTH_WORDS (256),
        .WAIT_STATES (0)
    ) dut0 (
        .i_pclk    (clk),
        .i_presetn (presetn),
        .i_psel    (b_psel),
        .i_penable (b_penable),
        .i_pwrite  (b_pwrite),
        .i_paddr   (b_paddr),
        .i_pwdata  (b_pwdata),
        .i_pstrb   (b_pstrb),
        .o_prdata  (b_prdata),
        .o_pready  (b_pready),
        .o_pslverr (b_pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transfer on the 2-wait-state instance; reports access cycles up to PREADY.
    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, output logic [31:0] rd, output logic err,
                            output int ncyc);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        ncyc = 0; rd = '0; err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ncyc = i + 1;
            if (pready) begin
                rd  = prdata;
                err = pslverr;
                break;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] addr, input logic [31:0] wd, input logic [3:0] strb,
                            input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        err;
        int          ncyc;
        apb_xfer(1'b1, addr, wd, strb, rd, err, ncyc);
        check({tag, "_cycles"}, 32'(ncyc), 32'd3);
        check({tag, "_slverr"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_ready_drop"}, {31'd0, pready}, 32'd0);
    endtask

    task automatic do_read(input logic [11:0] addr, input logic [31:0] exp_data,
                           input logic exp_err, input string tag);
        logic [31:0] rd;
        logic        err;
        int          ncyc;
        apb_xfer(1'b0, addr, 32'h0, 4'h0, rd, err, ncyc);
        check({tag, "_cycles"}, 32'(ncyc), 32'd3);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_slverr"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        int highs;
        presetn = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0; b_paddr = '0; b_pwdata = '0;
        b_pstrb = '0;

        // Reset state
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst0_pready", {31'd0, b_pready}, 32'd0);
        check("rst0_prdata", b_prdata, 32'd0);
        @(posedge clk); #1;
        presetn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_pready", {31'd0, pready}, 32'd0);
        check("idle_pslverr", {31'd0, pslverr}, 32'd0);
        check("idle_prdata", prdata, 32'd0);

        // Full write / read
        do_write(12'h010, 32'hDEADBEEF, 4'hF, 1'b0, "t2_wr");
        do_read(12'h010, 32'hDEADBEEF, 1'b0, "t2_rd");

        // Partial strobes
        do_write(12'h010, 32'h11223344, 4'b0101, 1'b0, "t3_wr");
        do_read(12'h010, 32'hDE22BE44, 1'b0, "t3_rd");

        // Zero strobes: legal no-op
        do_write(12'h010, 32'hFFFFFFFF, 4'h0, 1'b0, "strb0_wr");
        do_read(12'h010, 32'hDE22BE44, 1'b0, "strb0_rd");

        // Decode and alignment errors
        do_write(12'h000, 32'hA5A5A5A5, 4'hF, 1'b0, "t4_w0");
        do_write(12'h400, 32'hFFFFFFFF, 4'hF, 1'b1, "t4_oob_wr");
        do_write(12'h011, 32'hFFFFFFFF, 4'hF, 1'b1, "t4_mis_wr");
        do_read(12'h000, 32'hA5A5A5A5, 1'b0, "t4_rd_w0");
        do_read(12'h010, 32'hDE22BE44, 1'b0, "t4_rd_w4");
        do_read(12'h400, 32'h00000000, 1'b1, "t4_oob_rd");
        @(negedge clk);
        check("t4_slverr_clear", {31'd0, pslverr}, 32'd0);
        do_read(12'h010, 32'hDE22BE44, 1'b0, "t4_rd_after_err");

        // Abort by dropping PSEL in the first wait cycle
        do_write(12'h020, 32'h01020304, 4'hF, 1'b0, "t5_init");
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'h55AA55AA;
        pstrb = 4'hF;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b1;
        highs = 0;
        repeat (5) begin
            @(negedge clk);
            if (pready) highs++;
        end
        penable = 1'b0;
        check("t5_abort_ready", 32'(highs), 32'd0);
        do_read(12'h020, 32'h01020304, 1'b0, "t5_abort_rd");

        // Abort by reset in the first wait cycle
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'h55AA55AA;
        pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1; presetn = 1'b0;
        highs = 0;
        @(negedge clk);
        if (pready) highs++;
        @(posedge clk); #1;
        presetn = 1'b1;
        @(negedge clk);
        check("t5_rst_prdata", prdata, 32'd0);
        if (pready) highs++;
        repeat (3) begin
            @(negedge clk);
            if (pready) highs++;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        check("t5_rst_ready", 32'(highs), 32'd0);
        do_read(12'h020, 32'h01020304, 1'b0, "t5_rst_rd");

        // Zero wait states, back-to-back write then read
        @(posedge clk); #1;
        b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 12'h3FC;
        b_pwdata = 32'hCAFEF00D; b_pstrb = 4'hF;
        @(negedge clk);
        check("t6_wr_setup_ready", {31'd0, b_pready}, 32'd0);
        @(posedge clk); #1;
        b_penable = 1'b1;
        @(negedge clk);
        check("t6_wr_ready", {31'd0, b_pready}, 32'd1);
        check("t6_wr_slverr", {31'd0, b_pslverr}, 32'd0);
        @(posedge clk); #1;
        b_penable = 1'b0; b_pwrite = 1'b0; b_pwdata = 32'h0;
        @(negedge clk);
        check("t6_rd_setup_ready", {31'd0, b_pready}, 32'd0);
        @(posedge clk); #1;
        b_penable = 1'b1;
        @(negedge clk);
        check("t6_rd_ready", {31'd0, b_pready}, 32'd1);
        check("t6_rd_data", b_prdata, 32'hCAFEF00D);
        check("t6_rd_slverr", {31'd0, b_pslverr}, 32'd0);
        @(posedge clk); #1;
        b_psel = 1'b0; b_penable = 1'b0;
        @(negedge clk);
        check("t6_ready_drop", {31'd0, b_pready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
